alu_muldiv_unit: RTL and testbench
==================================

Name: alu_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide companion to the single-cycle integer ALU. Implements the RISC-V M-extension operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) at configurable width.
- Sits beside the ALU in the execute stage. It takes one operation at a time over a valid/ready handshake and returns a result plus the destination tag it was given.
- Uses a radix-2 iterative datapath: one bit per clock. Divide-by-zero and signed overflow take a fast path.

Parameters:
- WIDTH, 32: operand/result width, >= 4.
- TAG_WIDTH, 5: width of the tag carried from In_Tag to Out_Tag, untouched.

Ports:
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  synchronous active-low reset.
- In_Valid  input  1  operation request.
- In_Ready  output  1  unit can accept this cycle.
- LHS  input  WIDTH  operand A / dividend.
- RHS  input  WIDTH  operand B / divisor.
- Function  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- In_Tag  input  TAG_WIDTH  tag captured with the operation.
- Flush  input  1  synchronous kill of any accepted or in-flight operation.
- Out_Valid  output  1  Result/Out_Tag valid.
- Out_Ready  input  1  consumer takes the result.
- Result  output  WIDTH  registered result.
- Out_Tag  output  TAG_WIDTH  registered tag.
- Busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset values (Reset_n low at an edge):
  - state IDLE; Out_Valid=0, Result=0, Out_Tag=0, Busy=0, iteration counter=0.
  - Reset wins over every other input.
  - Reset mid-operation discards the operation; no Out_Valid for it.
- Accept:
  - An operation is accepted on an edge where In_Valid && In_Ready && !Flush.
  - LHS, RHS, Function and In_Tag are latched on that edge; inputs are don't-care afterwards.
- In_Ready:
  - High in IDLE.
  - High in DONE only while Out_Ready is high (back-to-back accept on the same edge the result is consumed).
  - Low in BUSY.
- States:
  - IDLE -> BUSY on accept, normal path.
  - IDLE -> DONE on accept, fast path.
  - BUSY stays exactly WIDTH cycles (counter WIDTH-1 down to 0), then -> DONE with the result registered.
  - DONE -> IDLE on Out_Ready without a new accept.
  - DONE -> BUSY/DONE on Out_Ready with a simultaneous accept.
- Latency:
  - Normal path: Out_Valid rises WIDTH+1 edges after the accepting edge (33 at WIDTH=32).
  - Fast path: Out_Valid rises on the edge after accept.
- Output hold: Out_Valid, Result and Out_Tag stay constant while Out_Valid && !Out_Ready.
- Signed handling:
  - Signed operands are converted to magnitudes at accept.
  - The unsigned core runs on the magnitudes.
  - Sign correction is applied when loading Result.
  - Signs used:
    - MULH: both operands signed.
    - MULHSU: LHS signed, RHS unsigned.
    - DIV/REM: quotient sign = sign(LHS) xor sign(RHS); remainder sign = sign(LHS).
- Products:
  - The full product is 2*WIDTH bits.
  - MUL returns the low WIDTH bits (identical for all signedness).
  - MULH/MULHSU/MULHU return the high WIDTH bits.
- Divider: restoring divide, quotient truncated toward zero; remainder satisfies LHS = Q*RHS + R.
- Fast path (decided at accept, no BUSY cycles):
  - RHS==0:
    - DIV/DIVU return all-ones.
    - REM/REMU return LHS.
  - DIV with LHS = most negative and RHS = all-ones returns LHS; REM for the same operands returns 0.
  - Multiplies never take the fast path.
- Flush:
  - In BUSY or DONE, returns to IDLE next edge and drops Out_Valid; Result and Out_Tag are not cleared.
  - Flush with In_Valid in IDLE: no accept.
  - Flush has no effect in IDLE otherwise.
- No pipelining: at most one operation is in flight.

Test Plan:
- MUL LHS=7, RHS=0xFFFFFFFD (-3), Out_Ready=1 -> Out_Valid exactly 33 edges after accept, Result=0xFFFFFFEB, Out_Tag echoes In_Tag=0x1A.
- Multiply-high with LHS=RHS=0xFFFFFFFF:
  - MULH -> 0x00000000.
  - MULHSU -> 0xFFFFFFFF.
  - MULHU -> 0xFFFFFFFE.
  - Separately, MULH 0x80000000 x 0x80000000 -> 0x40000000.
- Divide/remainder:
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
  - Each result at 33 edges.
- Fast path, each with Out_Valid one edge after accept:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- Backpressure:
  - Hold Out_Ready=0 for 10 cycles after Out_Valid -> Result/Out_Tag stable, In_Ready=0.
  - Then raise Out_Ready with In_Valid=1 (MULHU) -> old result consumed and new operation accepted on the same edge; next Out_Valid 33 edges later.
- Abort mid-operation:
  - Assert Flush at BUSY cycle 10 -> no Out_Valid, In_Ready=1 next cycle.
  - Repeat with Reset_n=0 at BUSY cycle 10 -> all outputs at reset values; a subsequent MUL 3x4 returns 12.

Source files
------------

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: radix-2 iterative RISC-V M-extension multiply/divide unit.
// Ports: Clock, Reset_n (sync, active-low); request In_Valid/In_Ready with
// LHS, RHS, Function, In_Tag; Flush kill; result Out_Valid/Out_Ready with
// Result, Out_Tag; Busy while an operation is in BUSY or DONE.
module alu_muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic [WIDTH-1:0]     LHS,
    input  logic [WIDTH-1:0]     RHS,
    input  logic [2:0]           Function,
    input  logic [TAG_WIDTH-1:0] In_Tag,
    input  logic                 Flush,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [WIDTH-1:0]     Result,
    output logic [TAG_WIDTH-1:0] Out_Tag,
    output logic                 Busy
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]       hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2:0]           op_q, op_d;
    logic                 neg_q, neg_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;

    logic                 accept;
    logic                 in_sa, in_sb, in_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 rhs_zero, div_ovf, fast;
    logic [WIDTH-1:0]     fast_res;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift, div_diff;
    logic                 div_ge;
    logic [WIDTH:0]       hi_nx;
    logic [WIDTH-1:0]     lo_nx;
    logic [2*WIDTH-1:0]   full, full_s;
    logic [WIDTH-1:0]     quo_s, rem_s, final_res;

    assign In_Ready  = (state_q == S_IDLE) ||
                       ((state_q == S_DONE) && Out_Ready);
    assign accept    = In_Valid && In_Ready && !Flush;
    assign Out_Valid = (state_q == S_DONE);
    assign Busy      = (state_q != S_IDLE);
    assign Result    = result_q;
    assign Out_Tag   = out_tag_q;

    // Operand conditioning: the core only ever sees magnitudes; the
    // sign of the final answer is remembered in neg.
    always_comb begin
        in_sa = LHS[WIDTH-1] &&
                ((Function == F_MULH) || (Function == F_MULHSU) ||
                 (Function == F_DIV)  || (Function == F_REM));
        in_sb = RHS[WIDTH-1] &&
                ((Function == F_MULH) || (Function == F_DIV) ||
                 (Function == F_REM));
        a_mag  = in_sa ? -LHS : LHS;
        b_mag  = in_sb ? -RHS : RHS;
        // Remainder takes the dividend's sign; everything else the xor.
        in_neg = (Function == F_REM) ? in_sa : (in_sa ^ in_sb);

        rhs_zero = (RHS == '0);
        div_ovf  = ((Function == F_DIV) || (Function == F_REM)) &&
                   (LHS == MIN_NEG) && (RHS == '1);
        fast     = Function[2] && (rhs_zero || div_ovf);
        if (rhs_zero) begin
            fast_res = Function[1] ? LHS : '1;
        end else begin
            fast_res = Function[1] ? '0 : LHS;
        end
    end

    // One iteration of the shared datapath.
    // Multiply: shift-add, product accumulates in {hi, lo}.
    // Divide: restoring, remainder in hi, quotient shifts into lo.
    always_comb begin
        mul_sum   = hi_q + {1'b0, (lo_q[0] ? b_q : '0)};
        div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = (div_shift >= {1'b0, b_q});
        if (op_q[2]) begin
            hi_nx = div_ge ? div_diff : div_shift;
            lo_nx = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi_nx = {1'b0, mul_sum[WIDTH:1]};
            lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Sign correction applied to the post-final-iteration values.
    always_comb begin
        full   = {hi_nx[WIDTH-1:0], lo_nx};
        full_s = neg_q ? -full : full;
        quo_s  = neg_q ? -lo_nx : lo_nx;
        rem_s  = neg_q ? -hi_nx[WIDTH-1:0] : hi_nx[WIDTH-1:0];
        unique case (op_q)
            F_MUL:                     final_res = full_s[WIDTH-1:0];
            F_MULH, F_MULHSU, F_MULHU: final_res = full_s[2*WIDTH-1:WIDTH];
            default:                   final_res = op_q[1] ? rem_s : quo_s;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        op_d      = op_q;
        neg_d     = neg_q;
        tag_d     = tag_q;
        result_d  = result_q;
        out_tag_d = out_tag_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_BUSY: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = hi_nx;
                    lo_d  = lo_nx;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == '0) begin
                        state_d   = S_DONE;
                        cnt_d     = '0;
                        result_d  = final_res;
                        out_tag_d = tag_q;
                    end
                end
            end
            S_DONE: begin
                if (Flush || Out_Ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accept only happens from IDLE or a consumed DONE, so it can
        // override whatever the state decode chose.
        if (accept) begin
            op_d    = Function;
            neg_d   = in_neg;
            tag_d   = In_Tag;
            hi_d    = '0;
            lo_d    = a_mag;
            b_d     = b_mag;
            if (fast) begin
                state_d   = S_DONE;
                cnt_d     = '0;
                result_d  = fast_res;
                out_tag_d = In_Tag;
            end else begin
                state_d = S_BUSY;
                cnt_d   = CNT_LAST;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            tag_q     <= '0;
            result_q  <= '0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            out_tag_q <= out_tag_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: directed table, corner sequences and random
// operations checked against an arithmetic reference model.
module tb_alu_muldiv_unit;

    logic        Clock;
    logic        Reset_n;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] LHS;
    logic [31:0] RHS;
    logic [2:0]  Function;
    logic [4:0]  In_Tag;
    logic        Flush;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Result;
    logic [4:0]  Out_Tag;
    logic        Busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_muldiv_unit #(.WIDTH(32), .TAG_WIDTH(5)) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .LHS      (LHS),
        .RHS      (RHS),
        .Function (Function),
        .In_Tag   (In_Tag),
        .Flush    (Flush),
        .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready),
        .Result   (Result),
        .Out_Tag  (Out_Tag),
        .Busy     (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Reference: straight M-extension arithmetic on 64-bit values.
    function automatic logic [31:0] model(input logic [2:0] fn,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'h0, a};
        logic [63:0] ub = {32'h0, b};
        int          ia = $signed(a);
        int          ib = $signed(b);
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (fn)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return ia / ib;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return ia % ib;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] fn,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        logic sdiv = (fn == 3'd4) || (fn == 3'd6);
        if (fn[2] && (b == 0)) return 1;
        if (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op with Out_Ready high; lat counts edges from the
    // accepting edge (edge 1) until Out_Valid is seen.
    task automatic run_op(input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          output logic [31:0] res, output logic [4:0] otag,
                          output int lat);
        In_Valid = 1'b1;
        Function = fn;
        LHS      = a;
        RHS      = b;
        In_Tag   = tag;
        step();
        In_Valid = 1'b0;
        LHS      = $urandom;
        RHS      = $urandom;
        Function = 3'($urandom);
        In_Tag   = 5'($urandom);
        lat = 1;
        while (!Out_Valid && lat < 100) begin
            step();
            lat++;
        end
        res  = Result;
        otag = Out_Tag;
        step();
    endtask

    vec_t        vecs[14];
    logic [31:0] res;
    logic [4:0]  otag;
    int          lat;
    logic [31:0] prev;
    int          seen;

    initial begin
        vecs[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, 5'h1A, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h01, 32'h0, 33};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h02,
                     32'hFFFF_FFFF, 33};
        vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03,
                     32'hFFFF_FFFE, 33};
        vecs[4]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'h04,
                     32'h4000_0000, 33};
        vecs[5]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 5'h05, 32'hFFFF_FFFD, 33};
        vecs[6]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 5'h06, 32'hFFFF_FFFF, 33};
        vecs[7]  = '{3'd5, 32'd100, 32'd7, 5'h07, 32'd14, 33};
        vecs[8]  = '{3'd7, 32'd100, 32'd7, 5'h08, 32'd2, 33};
        vecs[9]  = '{3'd5, 32'd5, 32'd0, 5'h09, 32'hFFFF_FFFF, 1};
        vecs[10] = '{3'd6, 32'd5, 32'd0, 5'h0A, 32'd5, 1};
        vecs[11] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0B,
                     32'h8000_0000, 1};
        vecs[12] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0C, 32'h0, 1};
        vecs[13] = '{3'd0, 32'd3, 32'd4, 5'h1F, 32'd12, 33};

        Reset_n   = 1'b0;
        In_Valid  = 1'b1;
        LHS       = 32'd9;
        RHS       = 32'd0;
        Function  = 3'd5;
        In_Tag    = 5'h11;
        Flush     = 1'b0;
        Out_Ready = 1'b1;
        repeat (3) step();
        check("reset_out_valid", {31'h0, Out_Valid}, 32'h0);
        check("reset_result", Result, 32'h0);
        check("reset_out_tag", {27'h0, Out_Tag}, 32'h0);
        check("reset_busy", {31'h0, Busy}, 32'h0);
        In_Valid = 1'b0;
        Reset_n  = 1'b1;
        step();
        check("idle_in_ready", {31'h0, In_Ready}, 32'h1);

        foreach (vecs[i]) begin
            run_op(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].tag,
                   res, otag, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_tag", i), {27'h0, otag},
                  {27'h0, vecs[i].tag});
            check($sformatf("vec%0d_latency", i), 32'(lat),
                  32'(vecs[i].lat));
        end

        // Backpressure, then consume and accept on the same edge.
        Out_Ready = 1'b0;
        In_Valid  = 1'b1;
        Function  = 3'd5;
        LHS       = 32'd100;
        RHS       = 32'd7;
        In_Tag    = 5'h03;
        step();
        In_Valid = 1'b0;
        lat = 1;
        while (!Out_Valid && lat < 100) begin
            step();
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd33);
        for (int k = 0; k < 10; k++) begin
            step();
            check("bp_hold_valid", {31'h0, Out_Valid}, 32'h1);
            check("bp_hold_result", Result, 32'd14);
            check("bp_hold_tag", {27'h0, Out_Tag}, 32'h3);
            check("bp_in_ready", {31'h0, In_Ready}, 32'h0);
        end
        Out_Ready = 1'b1;
        In_Valid  = 1'b1;
        Function  = 3'd3;
        LHS       = 32'hFFFF_FFFF;
        RHS       = 32'hFFFF_FFFF;
        In_Tag    = 5'h09;
        #1;
        check("b2b_in_ready", {31'h0, In_Ready}, 32'h1);
        step();
        In_Valid = 1'b0;
        check("b2b_consumed", {31'h0, Out_Valid}, 32'h0);
        check("b2b_busy", {31'h0, Busy}, 32'h1);
        lat = 1;
        while (!Out_Valid && lat < 100) begin
            step();
            lat++;
        end
        check("b2b_latency", 32'(lat), 32'd33);
        check("b2b_result", Result, 32'hFFFF_FFFE);
        check("b2b_tag", {27'h0, Out_Tag}, 32'h9);
        step();
        prev = Result;

        // Flush with a request while idle must not accept.
        In_Valid = 1'b1;
        Flush    = 1'b1;
        Function = 3'd0;
        step();
        In_Valid = 1'b0;
        Flush    = 1'b0;
        check("idle_flush_busy", {31'h0, Busy}, 32'h0);

        // Flush at BUSY cycle 10.
        In_Valid = 1'b1;
        Function = 3'd0;
        LHS      = 32'd5;
        RHS      = 32'd6;
        In_Tag   = 5'h04;
        step();
        In_Valid = 1'b0;
        repeat (9) step();
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("flush_out_valid", {31'h0, Out_Valid}, 32'h0);
        check("flush_in_ready", {31'h0, In_Ready}, 32'h1);
        check("flush_busy", {31'h0, Busy}, 32'h0);
        check("flush_result_kept", Result, prev);
        seen = 0;
        repeat (40) begin
            step();
            if (Out_Valid) seen++;
        end
        check("flush_no_valid", 32'(seen), 32'd0);

        // Reset at BUSY cycle 10.
        In_Valid = 1'b1;
        Function = 3'd4;
        LHS      = 32'd77;
        RHS      = 32'd3;
        In_Tag   = 5'h15;
        step();
        In_Valid = 1'b0;
        repeat (9) step();
        Reset_n = 1'b0;
        step();
        check("rst_out_valid", {31'h0, Out_Valid}, 32'h0);
        check("rst_result", Result, 32'h0);
        check("rst_out_tag", {27'h0, Out_Tag}, 32'h0);
        check("rst_busy", {31'h0, Busy}, 32'h0);
        Reset_n = 1'b1;
        run_op(3'd0, 32'd3, 32'd4, 5'h02, res, otag, lat);
        check("post_rst_result", res, 32'd12);
        check("post_rst_latency", 32'(lat), 32'd33);

        // Random operations against the reference model.
        for (int n = 0; n < 150; n++) begin
            logic [2:0]  fn;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  tg;
            fn = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            tg = 5'($urandom);
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 300));
                3: a = 32'($signed(-$urandom_range(1, 1000)));
                default: ;
            endcase
            run_op(fn, a, b, tg, res, otag, lat);
            check($sformatf("rnd%0d_f%0d_result", n, fn), res,
                  model(fn, a, b));
            check($sformatf("rnd%0d_tag", n), {27'h0, otag}, {27'h0, tg});
            check($sformatf("rnd%0d_latency", n), 32'(lat),
                  32'(model_lat(fn, a, b)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
